// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller.
// MULTICYCLE_CTRL_TRAP_EN adds the TRAP state for illegal opcodes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_RWB,
    S_IWB,
    S_BRANCH,
    S_JUMP
`ifdef MULTICYCLE_CTRL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  typedef enum logic [2:0] {
    C_NOP,
    C_RTYPE,
    C_ADDI,
    C_LW,
    C_SW,
    C_BEQ,
    C_J
  } op_class_e;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_R_LO = 5'h01;
  localparam logic [4:0] OP_R_HI = 5'h07;
  localparam logic [4:0] OP_ADDI = 5'h08;
  localparam logic [4:0] OP_LW   = 5'h10;
  localparam logic [4:0] OP_SW   = 5'h11;
  localparam logic [4:0] OP_BEQ  = 5'h18;
  localparam logic [4:0] OP_J    = 5'h1C;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier with illegal-opcode flag.
// Any set bit above bit 4 makes the opcode illegal.
module mc_opdecode
  import mc_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_e           op_class,
  output logic                illegal
);

  logic [OPCODE_W-1:0] hi;
  logic [4:0]          lo;

  assign hi = opcode >> 5;
  assign lo = opcode[4:0];

  always_comb begin
    op_class = C_NOP;
    illegal  = 1'b0;
    unique case (1'b1)
      (lo == OP_NOP):  op_class = C_NOP;
      (lo >= OP_R_LO && lo <= OP_R_HI):
        op_class = C_RTYPE;
      (lo == OP_ADDI): op_class = C_ADDI;
      (lo == OP_LW):   op_class = C_LW;
      (lo == OP_SW):   op_class = C_SW;
      (lo == OP_BEQ):  op_class = C_BEQ;
      (lo == OP_J):    op_class = C_J;
      default:         illegal  = 1'b1;
    endcase
    if (hi != '0) illegal = 1'b1;
    if (illegal) op_class = C_NOP;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: Moore FSM with multi-beat fetch.
// MULTICYCLE_CTRL_TRAP_EN makes illegal opcodes lock into TRAP.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int IR_WORDS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                memread,
  output logic                memwrite,
  output logic                data_not_instr,
  output logic [IR_WORDS-1:0] ir_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                trap
);

  localparam int KW = (IR_WORDS > 1) ? $clog2(IR_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(IR_WORDS - 1);

  state_e    state;
  logic [KW-1:0] k;
  op_class_e cls;
  logic      illegal;

  mc_opdecode #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode   (opcode),
    .op_class (cls),
    .illegal  (illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH:
          if (mem_ready) begin
            if (k == K_LAST) begin
              k     <= '0;
              state <= S_DECODE;
            end else begin
              k <= k + KW'(1);
            end
          end
        S_DECODE:
          if (illegal) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            state <= S_TRAP;
`else
            state <= S_FETCH;
`endif
          end else begin
            case (cls)
              C_LW, C_SW:       state <= S_MEMADR;
              C_RTYPE, C_ADDI:  state <= S_EXEC;
              C_BEQ:            state <= S_BRANCH;
              C_J:              state <= S_JUMP;
              default:          state <= S_FETCH;
            endcase
          end
        S_MEMADR:
          state <= (cls == C_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD: if (mem_ready) state <= S_MEMWB;
        S_MEMWR: if (mem_ready) state <= S_FETCH;
        S_EXEC:
          state <= (cls == C_ADDI) ? S_IWB : S_RWB;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  // Beat strobes in FETCH follow mem_ready; everything else is per-state.
  always_comb begin
    memread        = 1'b0;
    memwrite       = 1'b0;
    data_not_instr = 1'b0;
    ir_write       = '0;
    alu_src_a      = 1'b0;
    alu_src_b      = SRCB_REG;
    alu_op         = ALU_ADD;
    pc_source      = PC_ALU;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    reg_write      = 1'b0;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    trap           = 1'b0;
    case (state)
      S_FETCH: begin
        memread   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          pc_write = 1'b1;
          ir_write = IR_WORDS'(1) << k;
        end
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        memread        = 1'b1;
        data_not_instr = 1'b1;
      end
      S_MEMWR: begin
        memwrite       = 1'b1;
        data_not_instr = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        alu_src_b = (cls == C_ADDI) ? SRCB_IMM : SRCB_REG;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_JUMP;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      S_TRAP: trap = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl (IR_WORDS=3 and IR_WORDS=1 builds).
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] opcode = '0;
  logic [6:0] op7 = '0;
  logic       mem_ready = 1'b1;

  logic       memread, memwrite, dni;
  logic [2:0] ir_write;
  logic       asa;
  logic [1:0] asb, aop, pcs;
  logic       pcw, pcwc, rw, rd, m2r, trap;

  logic       memread1, memwrite1, dni1;
  logic [0:0] ir_write1;
  logic       asa1;
  logic [1:0] asb1, aop1, pcs1;
  logic       pcw1, pcwc1, rw1, rd1, m2r1, trap1;

  int checks = 0;
  int errors = 0;

  logic [18:0] exp_q[$];
  logic        p_rdy[$];
  logic [6:0]  p_op[$];
  logic [18:0] p_exp[$];

  wire [18:0] obs = {trap, memread, memwrite, dni, ir_write,
                     asa, asb, aop, pcs, pcw, pcwc, rw, rd, m2r};
  wire [18:0] obs1 = {trap1, memread1, memwrite1, dni1, 2'b00,
                      ir_write1, asa1, asb1, aop1, pcs1,
                      pcw1, pcwc1, rw1, rd1, m2r1};

  always #5 clk = ~clk;

  multicycle_ctrl u0 (
    .clk(clk), .reset(reset), .opcode(opcode),
    .mem_ready(mem_ready), .memread(memread),
    .memwrite(memwrite), .data_not_instr(dni),
    .ir_write(ir_write), .alu_src_a(asa),
    .alu_src_b(asb), .alu_op(aop), .pc_source(pcs),
    .pc_write(pcw), .pc_write_cond(pcwc),
    .reg_write(rw), .reg_dst(rd), .mem_to_reg(m2r),
    .trap(trap)
  );

  multicycle_ctrl #(.OPCODE_W(7), .IR_WORDS(1)) u1 (
    .clk(clk), .reset(reset), .opcode(op7),
    .mem_ready(mem_ready), .memread(memread1),
    .memwrite(memwrite1), .data_not_instr(dni1),
    .ir_write(ir_write1), .alu_src_a(asa1),
    .alu_src_b(asb1), .alu_op(aop1), .pc_source(pcs1),
    .pc_write(pcw1), .pc_write_cond(pcwc1),
    .reg_write(rw1), .reg_dst(rd1), .mem_to_reg(m2r1),
    .trap(trap1)
  );

  function automatic logic [18:0] ov(
    input logic t, mr, mw, dn,
    input logic [2:0] irw,
    input logic a,
    input logic [1:0] b, op, pc,
    input logic w, wc, r, d, m
  );
    return {t, mr, mw, dn, irw, a, b, op, pc, w, wc, r, d, m};
  endfunction

  function automatic logic [18:0] e_idle();
    return '0;
  endfunction

  function automatic logic [18:0] e_fetch(input int k,
                                          input logic r);
    logic [2:0] one;
    one = 3'b001;
    return ov(0, 1, 0, 0, r ? (one << k) : 3'b000,
              0, 2'b01, 2'b00, 2'b00, r, 0, 0, 0, 0);
  endfunction

  function automatic logic [18:0] e_decode();
    return ov(0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00,
              0, 0, 0, 0, 0);
  endfunction

  function automatic logic [18:0] e_memadr();
    return ov(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00,
              0, 0, 0, 0, 0);
  endfunction

  function automatic logic [18:0] e_memrd();
    return ov(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00,
              0, 0, 0, 0, 0);
  endfunction

  function automatic logic [18:0] e_memwr();
    return ov(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00,
              0, 0, 0, 0, 0);
  endfunction

  function automatic logic [18:0] e_memwb();
    return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00,
              0, 0, 1, 0, 1);
  endfunction

  function automatic logic [18:0] e_exec(input logic addi);
    return ov(0, 0, 0, 0, 0, 1, addi ? 2'b10 : 2'b00,
              2'b10, 2'b00, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [18:0] e_wb(input logic rdst);
    return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00,
              0, 0, 1, rdst, 0);
  endfunction

  function automatic logic [18:0] e_branch();
    return ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01,
              0, 1, 0, 0, 0);
  endfunction

  function automatic logic [18:0] e_jump();
    return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10,
              1, 0, 0, 0, 0);
  endfunction

  function automatic logic [18:0] e_trap();
    return ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00,
              0, 0, 0, 0, 0);
  endfunction

  function automatic void pl(input logic r,
                             input logic [6:0] o,
                             input logic [18:0] x);
    p_rdy.push_back(r);
    p_op.push_back(o);
    p_exp.push_back(x);
  endfunction

  function automatic void pf(input logic [6:0] o);
    for (int k = 0; k < 3; k++) pl(1'b1, o, e_fetch(k, 1'b1));
  endfunction

  task automatic drive(input logic r, input logic [6:0] o,
                       input logic [18:0] x);
    @(posedge clk);
    #1;
    mem_ready = r;
    opcode    = o[4:0];
    op7       = o;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    logic [18:0] x;
    int i;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", obs, 19'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.push_back(e_idle());
    @(negedge clk);
    x = exp_q.pop_front();
    checks++;
    if (obs !== x) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", obs, x);
    end
    pf(7'h00);
    pl(1'b1, 7'h00, e_decode());
    i = 0;
    while (p_exp.size() > 0) begin
      drive(p_rdy.pop_front(), p_op.pop_front(),
            p_exp.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL reset_fetch[%0d]: got %h want %h",
                 i, obs, x);
      end
      i++;
    end
  endtask

  task automatic test_lw_stall();
    logic [18:0] x;
    int i;
    pf(7'h1F);
    pl(1'b1, 7'h10, e_decode());
    pl(1'b1, 7'h10, e_memadr());
    for (int j = 0; j < 4; j++) pl(1'b0, 7'h11, e_memrd());
    pl(1'b1, 7'h08, e_memrd());
    pl(1'b1, 7'h00, e_memwb());
    pf(7'h00);
    pl(1'b1, 7'h00, e_decode());
    i = 0;
    while (p_exp.size() > 0) begin
      drive(p_rdy.pop_front(), p_op.pop_front(),
            p_exp.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL lw[%0d]: got %h want %h", i, obs, x);
      end
      i++;
    end
  endtask

  task automatic test_sw();
    logic [18:0] x;
    int i;
    pf(7'h00);
    pl(1'b1, 7'h11, e_decode());
    pl(1'b1, 7'h11, e_memadr());
    pl(1'b0, 7'h10, e_memwr());
    pl(1'b1, 7'h10, e_memwr());
    i = 0;
    while (p_exp.size() > 0) begin
      drive(p_rdy.pop_front(), p_op.pop_front(),
            p_exp.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL sw[%0d]: got %h want %h", i, obs, x);
      end
      i++;
    end
  endtask

  task automatic test_rtype();
    logic [18:0] x;
    int i;
    pf(7'h00);
    pl(1'b1, 7'h03, e_decode());
    pl(1'b1, 7'h07, e_exec(1'b0));
    pl(1'b1, 7'h08, e_wb(1'b1));
    i = 0;
    while (p_exp.size() > 0) begin
      drive(p_rdy.pop_front(), p_op.pop_front(),
            p_exp.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL rtype[%0d]: got %h want %h", i, obs, x);
      end
      i++;
    end
  endtask

  task automatic test_addi_fetch_stall();
    logic [18:0] x;
    int i;
    pl(1'b1, 7'h00, e_fetch(0, 1'b1));
    pl(1'b0, 7'h00, e_fetch(1, 1'b0));
    pl(1'b0, 7'h00, e_fetch(1, 1'b0));
    pl(1'b1, 7'h00, e_fetch(1, 1'b1));
    pl(1'b1, 7'h00, e_fetch(2, 1'b1));
    pl(1'b1, 7'h08, e_decode());
    pl(1'b1, 7'h08, e_exec(1'b1));
    pl(1'b1, 7'h01, e_wb(1'b0));
    i = 0;
    while (p_exp.size() > 0) begin
      drive(p_rdy.pop_front(), p_op.pop_front(),
            p_exp.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL addi[%0d]: got %h want %h", i, obs, x);
      end
      i++;
    end
  endtask

  task automatic test_branch_jump();
    logic [18:0] x;
    int i;
    pf(7'h00);
    pl(1'b1, 7'h18, e_decode());
    pl(1'b1, 7'h18, e_branch());
    pf(7'h00);
    pl(1'b1, 7'h1C, e_decode());
    pl(1'b0, 7'h1C, e_jump());
    i = 0;
    while (p_exp.size() > 0) begin
      drive(p_rdy.pop_front(), p_op.pop_front(),
            p_exp.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL brj[%0d]: got %h want %h", i, obs, x);
      end
      i++;
    end
  endtask

  task automatic test_reset_midfetch();
    logic [18:0] x;
    int i;
    pl(1'b1, 7'h00, e_fetch(0, 1'b1));
    pl(1'b1, 7'h00, e_fetch(1, 1'b1));
    i = 0;
    while (p_exp.size() > 0) begin
      drive(p_rdy.pop_front(), p_op.pop_front(),
            p_exp.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL mid_pre[%0d]: got %h want %h",
                 i, obs, x);
      end
      i++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL mid_async: got %h want %h", obs, 19'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.push_back(e_idle());
    @(negedge clk);
    x = exp_q.pop_front();
    checks++;
    if (obs !== x) begin
      errors++;
      $display("FAIL mid_idle: got %h want %h", obs, x);
    end
    pf(7'h00);
    pl(1'b1, 7'h00, e_decode());
    i = 0;
    while (p_exp.size() > 0) begin
      drive(p_rdy.pop_front(), p_op.pop_front(),
            p_exp.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL mid_post[%0d]: got %h want %h",
                 i, obs, x);
      end
      i++;
    end
  endtask

  task automatic test_trap();
    logic [18:0] x;
    int i;
    pf(7'h00);
    pl(1'b1, 7'h1F, e_decode());
`ifdef MULTICYCLE_CTRL_TRAP_EN
    for (int j = 0; j < 20; j++)
      pl(1'b1, 7'(j), e_trap());
`else
    pf(7'h00);
    pl(1'b1, 7'h00, e_decode());
`endif
    i = 0;
    while (p_exp.size() > 0) begin
      drive(p_rdy.pop_front(), p_op.pop_front(),
            p_exp.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL trap[%0d]: got %h want %h", i, obs, x);
      end
      i++;
    end
  endtask

  task automatic test_ir1_opw7();
    logic [18:0] x;
    int i;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs1 !== 19'h0) begin
      errors++;
      $display("FAIL ir1_reset: got %h want %h", obs1, 19'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    op7 = 7'h40;
    exp_q.push_back(e_idle());
    @(negedge clk);
    x = exp_q.pop_front();
    checks++;
    if (obs1 !== x) begin
      errors++;
      $display("FAIL ir1_idle: got %h want %h", obs1, x);
    end
    pl(1'b1, 7'h40, e_fetch(0, 1'b1));
    pl(1'b1, 7'h40, e_decode());
`ifdef MULTICYCLE_CTRL_TRAP_EN
    for (int j = 0; j < 3; j++) pl(1'b1, 7'h10, e_trap());
`else
    pl(1'b1, 7'h10, e_fetch(0, 1'b1));
    pl(1'b1, 7'h10, e_decode());
    pl(1'b1, 7'h10, e_memadr());
`endif
    i = 0;
    while (p_exp.size() > 0) begin
      drive(p_rdy.pop_front(), p_op.pop_front(),
            p_exp.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      if (obs1 !== x) begin
        errors++;
        $display("FAIL ir1[%0d]: got %h want %h", i, obs1, x);
      end
      i++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw_stall();
    test_sw();
    test_rtype();
    test_addi_fetch_stall();
    test_branch_jump();
    test_reset_midfetch();
    test_trap();
`ifdef MULTICYCLE_CTRL_TRAP_EN
    #2 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
`endif
    test_ir1_opw7();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
